// File: rtl/imem_loader_ctrl_pkg.sv
// Shared CPU definitions: loader/run-control FSM encodings and instruction-memory geometry.
package imem_loader_ctrl_pkg;

    localparam int IM_AW_DEF = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

endpackage

// File: rtl/imem_loader_ctrl.sv
// Host program loader and CPU run control: streams words into IMEM, then releases the CPU.
// Writes are combinational with ld_vld (ld_rdy is held high for the whole LOAD state); status is registered.
module imem_loader_ctrl
    import imem_loader_ctrl_pkg::*;
#(
    parameter int IM_AW = IM_AW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_start,
    input  logic             run_start,
    input  logic             ld_vld,
    input  logic [31:0]      ld_data,
    input  logic             ld_last,
    output logic             ld_rdy,
    input  logic [31:0]      pc,
    input  logic             hlt_ID_EX,
    input  logic             hz_stall,
    input  logic             dm_stall,
    input  logic             flow_change_ID_EX,
    output logic             im_we,
    output logic [IM_AW-1:0] im_addr,
    output logic [31:0]      im_wdata,
    output logic             stall_IM_ID,
    output logic             flush_IM_ID,
    output logic             cpu_rst_n,
    output logic [1:0]       state,
    output logic             ld_err,
    output logic [IM_AW:0]   ld_cnt
);

    localparam logic [IM_AW-1:0] ADDR_MAX = '1;
    localparam logic [IM_AW:0]   CNT_ONE  = {{IM_AW{1'b0}}, 1'b1};

    state_t           state_q;
    state_t           state_nxt;
    logic [IM_AW:0]   cnt_q;
    logic             err_q;
    logic             cpu_rst_n_q;
    logic             accept;
    logic             load_entry;
    logic             err_set;
    logic [IM_AW-1:0] load_addr;
    logic             unused_pc;

    // The word counter doubles as the load address; its extra MSB only matters for ld_cnt.
    assign load_addr  = cnt_q[IM_AW-1:0];
    assign accept     = (state_q == ST_LOAD) && ld_vld;
    assign load_entry = (state_nxt == ST_LOAD) && (state_q != ST_LOAD);
    assign unused_pc  = ^pc[31:IM_AW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            cpu_rst_n_q <= (state_nxt == ST_RUN) || (state_nxt == ST_HALT);
        end
    end

    always_comb begin
        state_nxt = state_q;
        err_set   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                if (ld_start)       state_nxt = ST_LOAD;
                else if (run_start) state_nxt = ST_RUN;
            end
            ST_LOAD: begin
                if (accept) begin
                    if (ld_last) begin
                        state_nxt = ST_RUN;
                    end else if (load_addr == ADDR_MAX) begin
                        state_nxt = ST_IDLE;
                        err_set   = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (hlt_ID_EX) state_nxt = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (load_entry)  cnt_q <= '0;
            else if (accept) cnt_q <= cnt_q + CNT_ONE;

            if (load_entry)   err_q <= 1'b0;
            else if (err_set) err_q <= 1'b1;
        end
    end

    always_comb begin
        ld_rdy      = 1'b0;
        im_we       = 1'b0;
        im_addr     = pc[IM_AW-1:0];
        im_wdata    = 32'd0;
        stall_IM_ID = 1'b1;
        flush_IM_ID = 1'b0;
        if (state_q == ST_LOAD) begin
            ld_rdy   = 1'b1;
            im_we    = ld_vld;
            im_addr  = load_addr;
            im_wdata = ld_data;
        end
        if (state_q == ST_RUN) begin
            stall_IM_ID = hz_stall | dm_stall;
            flush_IM_ID = flow_change_ID_EX & ~(hz_stall | dm_stall);
        end
    end

    assign cpu_rst_n = cpu_rst_n_q;
    assign state     = state_q;
    assign ld_err    = err_q;
    assign ld_cnt    = cnt_q;

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Directed bench for imem_loader_ctrl with a queue-based scoreboard for IMEM writes and status snapshots.
module tb_imem_loader_ctrl;
    import imem_loader_ctrl_pkg::*;

    localparam int TB_AW = 4;
    localparam logic [31:0] PC_VAL = 32'h0000_1235;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ld_start, run_start, ld_vld, ld_last;
    logic [31:0]      ld_data;
    logic             ld_rdy;
    logic [31:0]      pc;
    logic             hlt_ID_EX, hz_stall, dm_stall, flow_change_ID_EX;
    logic             im_we;
    logic [TB_AW-1:0] im_addr;
    logic [31:0]      im_wdata;
    logic             stall_IM_ID, flush_IM_ID, cpu_rst_n;
    logic [1:0]       state;
    logic             ld_err;
    logic [TB_AW:0]   ld_cnt;

    typedef struct {
        int     tag;
        state_t st;
        int     cnt;
        logic   err, crst, stall, flush, rdy, we;
        int     addr;
        logic [31:0] wdata;
    } st_exp_t;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_exp_t;

    st_exp_t st_q[$];
    wr_exp_t wr_q[$];
    int total = 0;
    int bad   = 0;
    int tagn  = 0;

    always #5 clk = ~clk;

    imem_loader_ctrl #(.IM_AW(TB_AW)) dut (
        .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .run_start(run_start),
        .ld_vld(ld_vld), .ld_data(ld_data), .ld_last(ld_last), .ld_rdy(ld_rdy),
        .pc(pc), .hlt_ID_EX(hlt_ID_EX), .hz_stall(hz_stall), .dm_stall(dm_stall),
        .flow_change_ID_EX(flow_change_ID_EX), .im_we(im_we), .im_addr(im_addr),
        .im_wdata(im_wdata), .stall_IM_ID(stall_IM_ID), .flush_IM_ID(flush_IM_ID),
        .cpu_rst_n(cpu_rst_n), .state(state), .ld_err(ld_err), .ld_cnt(ld_cnt)
    );

    task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s #%0d: got %h expected %h", name, tag, act, exp);
        end
    endtask

    // Monitor: consumes one expected write per im_we pulse and one status snapshot per cycle.
    always @(negedge clk) begin
        if (im_we) begin
            if (wr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wr_unexpected: got write addr %0d data %h expected no write", im_addr, im_wdata);
            end else begin
                wr_exp_t w;
                w = wr_q.pop_front();
                chk("wr_addr", w.addr, 32'(im_addr), 32'(w.addr));
                chk("wr_data", w.addr, im_wdata, w.data);
            end
        end
        if (st_q.size() != 0) begin
            st_exp_t s;
            s = st_q.pop_front();
            chk("state",       s.tag, 32'(state),       32'(s.st));
            chk("ld_cnt",      s.tag, 32'(ld_cnt),      32'(s.cnt));
            chk("ld_err",      s.tag, 32'(ld_err),      32'(s.err));
            chk("cpu_rst_n",   s.tag, 32'(cpu_rst_n),   32'(s.crst));
            chk("stall_IM_ID", s.tag, 32'(stall_IM_ID), 32'(s.stall));
            chk("flush_IM_ID", s.tag, 32'(flush_IM_ID), 32'(s.flush));
            chk("ld_rdy",      s.tag, 32'(ld_rdy),      32'(s.rdy));
            chk("im_we",       s.tag, 32'(im_we),       32'(s.we));
            chk("im_addr",     s.tag, 32'(im_addr),     32'(s.addr));
            chk("im_wdata",    s.tag, im_wdata,         s.wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input state_t st, input int cnt, input logic err, input logic crst,
                             input logic stall, input logic flush, input logic rdy, input logic we,
                             input int addr, input logic [31:0] wdata);
        st_exp_t s;
        tagn++;
        s.tag = tagn; s.st = st; s.cnt = cnt; s.err = err; s.crst = crst;
        s.stall = stall; s.flush = flush; s.rdy = rdy; s.we = we; s.addr = addr; s.wdata = wdata;
        st_q.push_back(s);
    endtask

    // Present one load word in LOAD at address idx; the accepting edge follows.
    task automatic send_word(input int idx, input logic [31:0] data, input logic last);
        wr_exp_t w;
        ld_vld = 1'b1; ld_data = data; ld_last = last;
        w.addr = idx; w.data = data;
        wr_q.push_back(w);
        expect_st(ST_LOAD, idx, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, idx, data);
        tick();
        ld_vld = 1'b0; ld_data = 32'd0; ld_last = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        ld_start = 0; run_start = 0; ld_vld = 0; ld_last = 0; ld_data = 0;
        pc = PC_VAL; hlt_ID_EX = 0; hz_stall = 0; dm_stall = 0; flow_change_ID_EX = 0;

        // Reset state, then release.
        repeat (2) tick();
        expect_st(ST_IDLE, 0, 0, 0, 1, 0, 0, 0, 5, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Load A0..A3, last on the fourth word.
        ld_start = 1;
        expect_st(ST_IDLE, 0, 0, 0, 1, 0, 0, 0, 5, 0);
        tick();
        ld_start = 0;
        for (int i = 0; i < 4; i++) send_word(i, 32'hA0 + 32'(i), i == 3);
        expect_st(ST_RUN, 4, 0, 1, 0, 0, 0, 0, 5, 0);
        tick();

        // Stall/flush interplay in RUN.
        dm_stall = 1; flow_change_ID_EX = 1;
        expect_st(ST_RUN, 4, 0, 1, 1, 0, 0, 0, 5, 0);
        tick();
        dm_stall = 0;
        expect_st(ST_RUN, 4, 0, 1, 0, 1, 0, 0, 5, 0);
        tick();
        hz_stall = 1;
        expect_st(ST_RUN, 4, 0, 1, 1, 0, 0, 0, 5, 0);
        tick();
        hz_stall = 0; flow_change_ID_EX = 0;
        ld_start = 1;
        expect_st(ST_RUN, 4, 0, 1, 0, 0, 0, 0, 5, 0);
        tick();
        ld_start = 0;
        expect_st(ST_RUN, 4, 0, 1, 0, 0, 0, 0, 5, 0);
        tick();

        // Halt beats simultaneous load/run requests.
        hlt_ID_EX = 1; ld_start = 1; run_start = 1;
        expect_st(ST_RUN, 4, 0, 1, 0, 0, 0, 0, 5, 0);
        tick();
        hlt_ID_EX = 0; ld_start = 0; run_start = 0; flow_change_ID_EX = 1;
        expect_st(ST_HALT, 4, 0, 1, 1, 0, 0, 0, 5, 0);
        tick();
        flow_change_ID_EX = 0;
        ld_start = 1;
        expect_st(ST_HALT, 4, 0, 1, 1, 0, 0, 0, 5, 0);
        tick();
        ld_start = 0;
        run_start = 1;
        expect_st(ST_LOAD, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        tick();
        run_start = 0;
        expect_st(ST_LOAD, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        tick();

        // Overflow: a full memory's worth of words with no ld_last.
        for (int i = 0; i < 16; i++) send_word(i, 32'h100 + 32'(i), 1'b0);
        expect_st(ST_IDLE, 16, 1, 0, 1, 0, 0, 0, 5, 0);
        tick();

        // ld_err persists through RUN/HALT until the next accepted ld_start.
        run_start = 1;
        expect_st(ST_IDLE, 16, 1, 0, 1, 0, 0, 0, 5, 0);
        tick();
        run_start = 0;
        hlt_ID_EX = 1;
        expect_st(ST_RUN, 16, 1, 1, 0, 0, 0, 0, 5, 0);
        tick();
        hlt_ID_EX = 0;
        ld_start = 1; run_start = 1;
        expect_st(ST_HALT, 16, 1, 1, 1, 0, 0, 0, 5, 0);
        tick();
        ld_start = 0; run_start = 0;
        expect_st(ST_LOAD, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        tick();

        // Reset during LOAD aborts and clears status without waiting for a clock.
        send_word(0, 32'h5A5A_0000, 1'b0);
        send_word(1, 32'h5A5A_0001, 1'b0);
        rst_n = 0; ld_vld = 1; ld_data = 32'h55;
        expect_st(ST_IDLE, 0, 0, 0, 1, 0, 0, 0, 5, 0);
        tick();
        rst_n = 1; ld_vld = 0; ld_data = 0;
        tick();

        // Simultaneous requests in IDLE: load wins.
        ld_start = 1; run_start = 1;
        expect_st(ST_IDLE, 0, 0, 0, 1, 0, 0, 0, 5, 0);
        tick();
        ld_start = 0; run_start = 0;
        send_word(0, 32'hDEAD_BEEF, 1'b1);
        expect_st(ST_RUN, 1, 0, 1, 0, 0, 0, 0, 5, 0);
        tick();

        repeat (3) tick();
        chk("wr_q_drained", 0, 32'(wr_q.size()), 32'd0);
        chk("st_q_drained", 0, 32'(st_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
